stopwatch_ctrl: RTL and testbench

Six-digit BCD stopwatch controller that sits directly upstream of the seven-segment decode/scan path. It debounces two raw push-buttons (start/pause and clear), runs an IDLE/RUN/PAUSE state machine, and advances a cascaded 000000–999999 BCD count on a programmable tick. Its packed BCD outputs drive the six per-digit segment decoders, which in turn feed the scan driver.

---
 rtl/seg_pkg.sv | 18 +
 rtl/key_debounce.sv | 59 +++++
 rtl/stopwatch_ctrl.sv | 121 ++++++++++++
 tb/tb_stopwatch_ctrl.sv | 191 +++++++++++++++++++
 4 files changed

// File: rtl/seg_pkg.sv
// Shared definitions for the stopwatch / seven-segment path: FSM encoding,
// digit count and the single-digit BCD increment.
package seg_pkg;

    localparam int NUM_DIGITS = 6;
    localparam int BCD_W      = 4 * NUM_DIGITS;

    localparam logic [3:0] BCD_MAX = 4'd9;

    localparam logic [1:0] IDLE  = 2'd0;
    localparam logic [1:0] RUN   = 2'd1;
    localparam logic [1:0] PAUSE = 2'd2;

    function automatic logic [3:0] bcd_next(input logic [3:0] d);
        return (d == BCD_MAX) ? 4'd0 : d + 4'd1;
    endfunction

endpackage

// File: rtl/key_debounce.sv
// Raw active-low push-button to a one-cycle press pulse: 2-FF synchronizer,
// stability counter, and falling-edge detect on the debounced level.
module key_debounce #(
    parameter int DEBOUNCE_CYC = 480_000
) (
    input  logic clk,
    input  logic rst_n,
    input  logic key_n,
    output logic press
);

    localparam int CW = $clog2(DEBOUNCE_CYC);
    localparam logic [CW-1:0] CNT_LAST = CW'(DEBOUNCE_CYC - 1);

    logic          sync1_q, sync1_d;
    logic          sync2_q, sync2_d;
    logic          stable_q, stable_d;
    logic          stable_dly_q, stable_dly_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic          press_q, press_d;

    always_comb begin
        sync1_d      = key_n;
        sync2_d      = sync1_q;
        stable_d     = stable_q;
        cnt_d        = '0;
        // Any sample agreeing with the stable level restarts the qualification window.
        if (sync2_q != stable_q) begin
            if (cnt_q == CNT_LAST) begin
                stable_d = sync2_q;
            end else begin
                cnt_d = cnt_q + CW'(1);
            end
        end
        stable_dly_d = stable_q;
        press_d      = stable_dly_q & ~stable_q;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync1_q      <= 1'b1;
            sync2_q      <= 1'b1;
            stable_q     <= 1'b1;
            stable_dly_q <= 1'b1;
            cnt_q        <= '0;
            press_q      <= 1'b0;
        end else begin
            sync1_q      <= sync1_d;
            sync2_q      <= sync2_d;
            stable_q     <= stable_d;
            stable_dly_q <= stable_dly_d;
            cnt_q        <= cnt_d;
            press_q      <= press_d;
        end
    end

    assign press = press_q;

endmodule

// File: rtl/stopwatch_ctrl.sv
// Six-digit BCD stopwatch: debounced start/pause and clear keys, run/pause FSM,
// tick prescaler and rippling BCD count feeding the segment decoders.
//
//   state | meaning
//   IDLE  | cleared, prescaler held at 0, waiting for start
//   RUN   | prescaler counting, bcd advances on each tick
//   PAUSE | prescaler and bcd frozen, start resumes the partial tick
module stopwatch_ctrl
    import seg_pkg::*;
#(
    parameter int TICK_DIV     = 2_400_000,
    parameter int DEBOUNCE_CYC = 480_000
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             key_start_n,
    input  logic             key_clr_n,
    output logic [BCD_W-1:0] bcd,
    output logic             running,
    output logic             overflow
);

    localparam int PW = $clog2(TICK_DIV);
    localparam logic [PW-1:0] PRESC_LAST = PW'(TICK_DIV - 1);

    logic             start_press, clr_press;
    logic [1:0]       state_q, state_d;
    logic [PW-1:0]    presc_q, presc_d;
    logic [BCD_W-1:0] bcd_q, bcd_d;
    logic             overflow_q, overflow_d;
    logic             running_q, running_d;

    logic [NUM_DIGITS-1:0] nines;
    logic [NUM_DIGITS-1:0] carry_in;
    logic [BCD_W-1:0]      bcd_inc;
    logic                  tick;
    logic                  wrap;

    key_debounce #(.DEBOUNCE_CYC(DEBOUNCE_CYC)) u_key_start (
        .clk   (clk),
        .rst_n (rst_n),
        .key_n (key_start_n),
        .press (start_press)
    );

    key_debounce #(.DEBOUNCE_CYC(DEBOUNCE_CYC)) u_key_clr (
        .clk   (clk),
        .rst_n (rst_n),
        .key_n (key_clr_n),
        .press (clr_press)
    );

    // Carry into a digit is the AND of all lower nines, so the whole cascade settles in one edge.
    for (genvar i = 0; i < NUM_DIGITS; i++) begin : g_digit
        assign nines[i] = (bcd_q[4*i +: 4] == BCD_MAX);
        if (i == 0) begin : g_lsd
            assign carry_in[i] = 1'b1;
        end else begin : g_upper
            assign carry_in[i] = &nines[i-1:0];
        end
        assign bcd_inc[4*i +: 4] = carry_in[i] ? bcd_next(bcd_q[4*i +: 4]) : bcd_q[4*i +: 4];
    end

    assign wrap = &nines;
    assign tick = (state_q == RUN) && (presc_q == PRESC_LAST);

    always_comb begin
        state_d    = state_q;
        presc_d    = presc_q;
        bcd_d      = bcd_q;
        overflow_d = overflow_q;
        if (clr_press) begin
            state_d    = IDLE;
            presc_d    = '0;
            bcd_d      = '0;
            overflow_d = 1'b0;
        end else begin
            if (tick) begin
                presc_d = '0;
                bcd_d   = bcd_inc;
                if (wrap) begin
                    overflow_d = 1'b1;
                end
            end else if (state_q == RUN) begin
                presc_d = presc_q + PW'(1);
            end else if (state_q == IDLE) begin
                presc_d = '0;
            end
            if (start_press) begin
                case (state_q)
                    IDLE:    state_d = RUN;
                    RUN:     state_d = PAUSE;
                    PAUSE:   state_d = RUN;
                    default: state_d = IDLE;
                endcase
            end
        end
        running_d = (state_d == RUN);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= IDLE;
            presc_q    <= '0;
            bcd_q      <= '0;
            overflow_q <= 1'b0;
            running_q  <= 1'b0;
        end else begin
            state_q    <= state_d;
            presc_q    <= presc_d;
            bcd_q      <= bcd_d;
            overflow_q <= overflow_d;
            running_q  <= running_d;
        end
    end

    assign bcd      = bcd_q;
    assign running  = running_q;
    assign overflow = overflow_q;

endmodule

// File: tb/tb_stopwatch_ctrl.sv
// Directed bench for stopwatch_ctrl with TICK_DIV=10, DEBOUNCE_CYC=4.
module tb_stopwatch_ctrl;

    logic        clk;
    logic        rst_n;
    logic        key_start_n;
    logic        key_clr_n;
    logic [23:0] bcd;
    logic        running;
    logic        overflow;

    int checks = 0;
    int errors = 0;
    int nib_bad = 0;

    stopwatch_ctrl #(.TICK_DIV(10), .DEBOUNCE_CYC(4)) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .key_start_n (key_start_n),
        .key_clr_n   (key_clr_n),
        .bcd         (bcd),
        .running     (running),
        .overflow    (overflow)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(negedge clk) begin
        if (rst_n) begin
            for (int d = 0; d < 6; d++) begin
                if (bcd[4*d +: 4] > 4'd9) nib_bad++;
            end
        end
    end

    task automatic edges(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic check_bcd(input string tag, input logic [23:0] obs, input logic [23:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic check_bit(input string tag, input logic obs, input logic exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%b expected=%b", tag, obs, exp);
        end
    endtask

    // Key held low long enough to register; returns just after the state update edge.
    task automatic press_start();
        key_start_n = 1'b0;
        edges(8);
        key_start_n = 1'b1;
    endtask

    initial begin
        rst_n       = 1'b0;
        key_start_n = 1'b1;
        key_clr_n   = 1'b1;
        edges(3);
        check_bcd("reset_bcd", bcd, 24'h000000);
        check_bit("reset_running", running, 1'b0);
        check_bit("reset_overflow", overflow, 1'b0);
        rst_n = 1'b1;
        edges(2);

        // start: key low for 20 cycles
        key_start_n = 1'b0;
        edges(7);
        check_bit("start_running_edge7", running, 1'b0);
        edges(1);
        check_bit("start_running_edge8", running, 1'b1);
        edges(9);
        check_bcd("start_bcd_before_tick", bcd, 24'h000000);
        edges(1);
        check_bcd("start_first_increment", bcd, 24'h000001);
        edges(2);
        key_start_n = 1'b1;
        edges(37);
        check_bcd("start_bcd_4", bcd, 24'h000004);
        edges(1);
        check_bcd("start_bcd_5", bcd, 24'h000005);
        check_bit("release_no_event", running, 1'b1);

        // asynchronous reset mid-count
        edges(3);
        rst_n = 1'b0;
        #1;
        check_bcd("midreset_bcd", bcd, 24'h000000);
        check_bit("midreset_running", running, 1'b0);
        check_bit("midreset_overflow", overflow, 1'b0);
        edges(2);
        rst_n = 1'b1;
        edges(30);
        check_bcd("postreset_no_count", bcd, 24'h000000);
        check_bit("postreset_idle", running, 1'b0);

        // 3-cycle glitch must be ignored
        key_start_n = 1'b0;
        edges(3);
        key_start_n = 1'b1;
        edges(10);
        check_bit("glitch_running", running, 1'b0);
        check_bcd("glitch_bcd", bcd, 24'h000000);

        // run 25 cycles then pause with prescaler at 5
        press_start();
        check_bit("run_entered", running, 1'b1);
        edges(17);
        press_start();
        check_bit("paused_running", running, 1'b0);
        check_bcd("paused_bcd", bcd, 24'h000002);
        edges(20);
        check_bcd("pause_holds_bcd", bcd, 24'h000002);
        press_start();
        check_bit("resumed_running", running, 1'b1);
        edges(4);
        check_bcd("resume_before_partial", bcd, 24'h000002);
        edges(1);
        check_bcd("resume_after_partial", bcd, 24'h000003);

        // carry 9 -> 10
        edges(60);
        check_bcd("carry_at_9", bcd, 24'h000009);
        edges(10);
        check_bcd("carry_to_10", bcd, 24'h000010);

        // carry 009999 -> 010000 from a preloaded value while paused
        press_start();
        check_bit("carry_paused", running, 1'b0);
        edges(8);
        force dut.bcd_q = 24'h009999;
        edges(1);
        release dut.bcd_q;
        check_bcd("preload_9999", bcd, 24'h009999);
        press_start();
        check_bcd("carry_resume_hold", bcd, 24'h009999);
        edges(1);
        check_bcd("carry_pre_tick", bcd, 24'h009999);
        edges(1);
        check_bcd("carry_to_10000", bcd, 24'h010000);

        // wrap 999999 -> 000000 with sticky overflow
        edges(8);
        press_start();
        check_bcd("wrap_paused_bcd", bcd, 24'h010001);
        edges(8);
        force dut.bcd_q = 24'h999999;
        edges(1);
        release dut.bcd_q;
        press_start();
        edges(3);
        check_bcd("wrap_pre_bcd", bcd, 24'h999999);
        check_bit("wrap_pre_overflow", overflow, 1'b0);
        edges(1);
        check_bcd("wrap_bcd", bcd, 24'h000000);
        check_bit("wrap_overflow", overflow, 1'b1);
        check_bit("wrap_running", running, 1'b1);
        edges(30);
        check_bit("overflow_sticky", overflow, 1'b1);
        check_bcd("count_after_wrap", bcd, 24'h000003);

        // simultaneous start and clear presses in RUN: clear wins
        key_start_n = 1'b0;
        key_clr_n   = 1'b0;
        edges(8);
        check_bit("clrprio_running", running, 1'b0);
        check_bcd("clrprio_bcd", bcd, 24'h000000);
        check_bit("clrprio_overflow", overflow, 1'b0);
        key_start_n = 1'b1;
        key_clr_n   = 1'b1;
        edges(20);
        check_bcd("clrprio_idle_no_count", bcd, 24'h000000);
        check_bit("clrprio_idle_running", running, 1'b0);

        check_bcd("nibbles_le_9", 24'(nib_bad), 24'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
